register_file: RTL and testbench

Per-warp, per-thread SIMT general-purpose register file for the GPU core pipeline.
- Two combinational read ports and one thread-masked write port. Each port addresses one architectural register of one warp, across all lanes.
- Holds a per-warp busy scoreboard: set by writes, cleared by the writeback/commit stage.
- Register 0 is hardwired to zero.

---
 rtl/register_file_pkg.sv | 35 +++
 rtl/rf_scoreboard.sv | 66 ++++++
 rtl/register_file.sv | 136 +++++++++++++
 tb/tb_register_file.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared types and constants for the SIMT register file.
// Bundles the scoreboard request type and the index range check.
package register_file_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WARP_ID_W  = 6;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WARP_ID_W-1:0]  warp_id_t;
  typedef logic [DATA_W-1:0]     lane_data_t;

  typedef struct packed {
    logic      en;
    warp_id_t  wid;
    reg_addr_t ridx;
  } sb_req_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Nonzero register inside the configured register/warp range.
  function automatic logic in_range(
    input reg_addr_t ridx,
    input warp_id_t  wid,
    input int        nregs,
    input int        nwarps
  );
    return (ridx != '0)
      && (32'(ridx) < 32'(nregs))
      && (32'(wid) < 32'(nwarps));
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-warp busy bits: set on accepted writes, cleared by commit.
// A set and clear of the same bit in one cycle leaves it set.
module rf_scoreboard
  import register_file_pkg::*;
#(
  parameter int NUM_REGISTERS = 32,
  parameter int NUM_WARPS     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  sb_req_t                  set_req,
  input  sb_req_t                  clr_req,
  output logic [NUM_REGISTERS-1:0] busy [NUM_WARPS]
);

  localparam int RI_W = idx_w(NUM_REGISTERS);
  localparam int WI_W = idx_w(NUM_WARPS);

  logic [NUM_REGISTERS-1:0] busy_q [NUM_WARPS];
  logic [NUM_REGISTERS-1:0] busy_d [NUM_WARPS];

  logic            set_ok;
  logic            clr_ok;
  logic [WI_W-1:0] set_w;
  logic [RI_W-1:0] set_r;
  logic [WI_W-1:0] clr_w;
  logic [RI_W-1:0] clr_r;

  assign set_ok = set_req.en
    && in_range(set_req.ridx, set_req.wid,
                NUM_REGISTERS, NUM_WARPS);
  assign clr_ok = clr_req.en
    && in_range(clr_req.ridx, clr_req.wid,
                NUM_REGISTERS, NUM_WARPS);

  assign set_w = set_req.wid[WI_W-1:0];
  assign set_r = set_req.ridx[RI_W-1:0];
  assign clr_w = clr_req.wid[WI_W-1:0];
  assign clr_r = clr_req.ridx[RI_W-1:0];

  // Next busy state: clear first so a same-bit set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_ok) begin
      busy_d[clr_w][clr_r] = 1'b0;
    end
    if (set_ok) begin
      busy_d[set_w][set_r] = 1'b1;
    end
    for (int w = 0; w < NUM_WARPS; w++) begin
      busy_d[w][0] = 1'b0;
    end
  end

  // Busy flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '{default: '0};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/register_file.sv
// SIMT register file: 2 read ports, 1 lane-masked write port.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file
  import register_file_pkg::*;
#(
  parameter int NUM_REGISTERS    = 32,
  parameter int THREADS_PER_WARP = 32,
  parameter int NUM_WARPS        = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  reg_addr_t                   rs1_addr,
  input  warp_id_t                    rs1_warp_id,
  output lane_data_t                  rs1_data [THREADS_PER_WARP],
  input  reg_addr_t                   rs2_addr,
  input  warp_id_t                    rs2_warp_id,
  output lane_data_t                  rs2_data [THREADS_PER_WARP],
  input  reg_addr_t                   rd_addr,
  input  warp_id_t                    rd_warp_id,
  input  lane_data_t                  rd_data [THREADS_PER_WARP],
  input  logic [THREADS_PER_WARP-1:0] rd_thread_mask,
  input  logic                        rd_write_en,
  output logic [NUM_REGISTERS-1:0]    register_busy [NUM_WARPS],
  input  reg_addr_t                   clear_busy_reg,
  input  warp_id_t                    clear_busy_warp,
  input  logic                        clear_busy_en
);

  localparam int RI_W = idx_w(NUM_REGISTERS);
  localparam int WI_W = idx_w(NUM_WARPS);

  lane_data_t regs_q
    [NUM_WARPS][NUM_REGISTERS][THREADS_PER_WARP];

  logic                        wr_ok;
  logic [THREADS_PER_WARP-1:0] wr_mask;
  logic [WI_W-1:0]             wr_w;
  logic [RI_W-1:0]             wr_r;

  logic            rs1_ok;
  logic            rs2_ok;
  logic [WI_W-1:0] rs1_w;
  logic [RI_W-1:0] rs1_r;
  logic [WI_W-1:0] rs2_w;
  logic [RI_W-1:0] rs2_r;

  sb_req_t set_req;
  sb_req_t clr_req;

  assign wr_ok = rd_write_en
    && in_range(rd_addr, rd_warp_id,
                NUM_REGISTERS, NUM_WARPS);
  assign wr_w  = rd_warp_id[WI_W-1:0];
  assign wr_r  = rd_addr[RI_W-1:0];

  assign rs1_ok = in_range(rs1_addr, rs1_warp_id,
                           NUM_REGISTERS, NUM_WARPS);
  assign rs2_ok = in_range(rs2_addr, rs2_warp_id,
                           NUM_REGISTERS, NUM_WARPS);
  assign rs1_w  = rs1_warp_id[WI_W-1:0];
  assign rs1_r  = rs1_addr[RI_W-1:0];
  assign rs2_w  = rs2_warp_id[WI_W-1:0];
  assign rs2_r  = rs2_addr[RI_W-1:0];

  // Lanes that actually update this cycle.
  always_comb begin
    wr_mask = '0;
    if (wr_ok) begin
      wr_mask = rd_thread_mask;
    end
  end

  // Storage: reset clears everything, else masked lane writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      for (int l = 0; l < THREADS_PER_WARP; l++) begin
        if (wr_mask[l]) begin
          regs_q[wr_w][wr_r][l] <= rd_data[l];
        end
      end
    end
  end

  // Read port 1: stored data, optionally overlaid by the write.
  always_comb begin
    for (int l = 0; l < THREADS_PER_WARP; l++) begin
      rs1_data[l] = '0;
      if (rs1_ok) begin
        rs1_data[l] = regs_q[rs1_w][rs1_r][l];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_mask[l] && rd_addr == rs1_addr
          && rd_warp_id == rs1_warp_id) begin
        rs1_data[l] = rd_data[l];
      end
`endif
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    for (int l = 0; l < THREADS_PER_WARP; l++) begin
      rs2_data[l] = '0;
      if (rs2_ok) begin
        rs2_data[l] = regs_q[rs2_w][rs2_r][l];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_mask[l] && rd_addr == rs2_addr
          && rd_warp_id == rs2_warp_id) begin
        rs2_data[l] = rd_data[l];
      end
`endif
    end
  end

  assign set_req = '{en: rd_write_en,
                     wid: rd_warp_id,
                     ridx: rd_addr};
  assign clr_req = '{en: clear_busy_en,
                     wid: clear_busy_warp,
                     ridx: clear_busy_reg};

  rf_scoreboard #(
    .NUM_REGISTERS (NUM_REGISTERS),
    .NUM_WARPS     (NUM_WARPS)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_req (set_req),
    .clr_req (clr_req),
    .busy    (register_busy)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed + random.
// Reference model is a plain array of registers and busy bits.
module tb_register_file;

  typedef logic [31:0] lanes_t [32];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, clear_busy_reg;
  logic [5:0]  rs1_warp_id, rs2_warp_id, rd_warp_id;
  logic [5:0]  clear_busy_warp;
  logic [31:0] rs1_data [32];
  logic [31:0] rs2_data [32];
  logic [31:0] rd_data [32];
  logic [31:0] rd_thread_mask;
  logic        rd_write_en, clear_busy_en;
  logic [31:0] register_busy [32];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  logic [31:0] mem [32][32][32];
  logic [31:0] busy_m [32];
  lanes_t      e1, e2, lit;

  register_file dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs1_addr        (rs1_addr),
    .rs1_warp_id     (rs1_warp_id),
    .rs1_data        (rs1_data),
    .rs2_addr        (rs2_addr),
    .rs2_warp_id     (rs2_warp_id),
    .rs2_data        (rs2_data),
    .rd_addr         (rd_addr),
    .rd_warp_id      (rd_warp_id),
    .rd_data         (rd_data),
    .rd_thread_mask  (rd_thread_mask),
    .rd_write_en     (rd_write_en),
    .register_busy   (register_busy),
    .clear_busy_reg  (clear_busy_reg),
    .clear_busy_warp (clear_busy_warp),
    .clear_busy_en   (clear_busy_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_lanes(input string nm,
                           input lanes_t act,
                           input lanes_t exp);
    int bad;
    bad = -1;
    for (int l = 31; l >= 0; l--)
      if (act[l] !== exp[l]) bad = l;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s lane %0d: got %h expected %h",
               nm, bad, act[bad], exp[bad]);
    end
  endtask

  function automatic logic [31:0] model_read(
    input logic [4:0] a, input logic [5:0] w, input int l);
    logic [31:0] v;
    v = '0;
    if (a != 0 && w < 32) v = mem[w[4:0]][a][l];
`ifdef REGFILE_BYPASS_EN
    if (rd_write_en && rd_addr != 0 && rd_warp_id < 32
        && a == rd_addr && w == rd_warp_id
        && rd_thread_mask[l])
      v = rd_data[l];
`endif
    return v;
  endfunction

  // Reference model update at each rising edge.
  always @(posedge clk) begin
    bit wv, cv;
    if (!rst_n) begin
      for (int w = 0; w < 32; w++) begin
        busy_m[w] = '0;
        for (int r = 0; r < 32; r++)
          for (int l = 0; l < 32; l++) mem[w][r][l] = '0;
      end
    end else begin
      wv = rd_write_en && rd_addr != 0 && rd_warp_id < 32;
      cv = clear_busy_en && clear_busy_reg != 0
        && clear_busy_warp < 32;
      if (wv)
        for (int l = 0; l < 32; l++)
          if (rd_thread_mask[l])
            mem[rd_warp_id[4:0]][rd_addr][l] = rd_data[l];
      if (cv && !(wv && rd_addr == clear_busy_reg
                  && rd_warp_id == clear_busy_warp))
        busy_m[clear_busy_warp[4:0]][clear_busy_reg] = 1'b0;
      if (wv) busy_m[rd_warp_id[4:0]][rd_addr] = 1'b1;
    end
  end

  // Compare every cycle at the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      int bw;
      for (int l = 0; l < 32; l++) begin
        e1[l] = model_read(rs1_addr, rs1_warp_id, l);
        e2[l] = model_read(rs2_addr, rs2_warp_id, l);
      end
      chk_lanes("rs1_model", rs1_data, e1);
      chk_lanes("rs2_model", rs2_data, e2);
      bw = 0;
      for (int w = 31; w >= 0; w--)
        if (register_busy[w] !== busy_m[w]) bw = w;
      chk("busy_model", register_busy[bw], busy_m[bw]);
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [5:0] w,
                       input logic [31:0] base,
                       input logic [31:0] m);
    rd_addr = a;
    rd_warp_id = w;
    rd_thread_mask = m;
    for (int l = 0; l < 32; l++) rd_data[l] = base + 32'(l);
    rd_write_en = 1'b1;
    cyc();
    rd_write_en = 1'b0;
  endtask

  task automatic rd_both(input logic [4:0] a, input logic [5:0] w);
    rs1_addr = a;
    rs1_warp_id = w;
    rs2_addr = a;
    rs2_warp_id = w;
    #1;
  endtask

  function automatic int busy_ones();
    int n;
    n = 0;
    for (int w = 0; w < 32; w++) n += $countones(register_busy[w]);
    return n;
  endfunction

  initial begin
    rst_n = 1'b0;
    rs1_addr = 0; rs1_warp_id = 0;
    rs2_addr = 0; rs2_warp_id = 0;
    rd_addr = 0; rd_warp_id = 0; rd_thread_mask = 0;
    rd_write_en = 0;
    clear_busy_reg = 0; clear_busy_warp = 0; clear_busy_en = 0;
    for (int l = 0; l < 32; l++) rd_data[l] = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    chk_on = 1'b1;

    for (int l = 0; l < 32; l++) lit[l] = '0;
    rd_both(5, 0);
    chk_lanes("reset_read", rs1_data, lit);
    chk("reset_busy", 32'(busy_ones()), 32'd0);

    write(5, 0, 32'hA000_0000, 32'hFFFF_FFFF);
    rd_both(5, 0);
    for (int l = 0; l < 32; l++) lit[l] = 32'hA000_0000 + 32'(l);
    chk_lanes("basic_rs1", rs1_data, lit);
    chk_lanes("basic_rs2", rs2_data, lit);

    write(10, 1, 32'h1111_1111, 32'hFFFF_FFFF);
    for (int l = 0; l < 32; l++) rd_data[l] = '0;
    write(10, 1, 32'hB000_0000, 32'h5555_5555);
    rd_both(10, 1);
    for (int l = 0; l < 32; l++)
      lit[l] = (l % 2 == 0) ? 32'hB000_0000 + 32'(l)
                            : 32'h1111_1111 + 32'(l);
    chk_lanes("masked", rs1_data, lit);

    for (int w = 0; w < 8; w++)
      write(15, 6'(w), 32'hC000_0000 + 32'(w << 16), '1);
    for (int w = 0; w < 32; w++) begin
      rs1_addr = 15;
      rs1_warp_id = 6'(w);
      #1;
      for (int l = 0; l < 32; l++)
        lit[l] = (w < 8) ? 32'hC000_0000 + 32'(w << 16) + 32'(l)
                         : 32'h0;
      chk_lanes($sformatf("iso_w%0d", w), rs1_data, lit);
      cyc();
    end

    write(0, 0, 32'hD000_0000, '1);
    rd_both(0, 0);
    for (int l = 0; l < 32; l++) lit[l] = '0;
    chk_lanes("r0_read", rs1_data, lit);
    chk("r0_busy", 32'(register_busy[0][0]), 32'd0);

    chk("sb_pre", 32'(register_busy[2][20]), 32'd0);
    write(20, 2, 32'h0, 32'h0);
    chk("sb_set", 32'(register_busy[2][20]), 32'd1);
    chk("sb_nb1", 32'(register_busy[2][19]), 32'd0);
    chk("sb_nb2", 32'(register_busy[3][20]), 32'd0);
    clear_busy_reg = 20;
    clear_busy_warp = 2;
    clear_busy_en = 1'b1;
    cyc();
    clear_busy_en = 1'b0;
    chk("sb_clr", 32'(register_busy[2][20]), 32'd0);
    clear_busy_en = 1'b1;
    write(20, 2, 32'h0, '1);
    clear_busy_en = 1'b0;
    chk("sb_setwins", 32'(register_busy[2][20]), 32'd1);

    write(7, 3, 32'hE000_0000, '1);
    rd_addr = 7;
    rd_warp_id = 3;
    rd_thread_mask = 32'h0000_FFFF;
    for (int l = 0; l < 32; l++) rd_data[l] = 32'hF000_0000 + 32'(l);
    rd_write_en = 1'b1;
    rst_n = 1'b0;
    rd_both(7, 3);
    for (int l = 0; l < 32; l++) begin
`ifdef REGFILE_BYPASS_EN
      lit[l] = (l < 16) ? 32'hF000_0000 + 32'(l)
                        : 32'hE000_0000 + 32'(l);
`else
      lit[l] = 32'hE000_0000 + 32'(l);
`endif
    end
    chk_lanes("rst_same_cycle", rs1_data, lit);
    cyc();
    rst_n = 1'b1;
    rd_write_en = 1'b0;
    #1;
    for (int l = 0; l < 32; l++) lit[l] = '0;
    chk_lanes("rst_r7", rs1_data, lit);
    rd_both(5, 0);
    chk_lanes("rst_r5", rs1_data, lit);
    chk("rst_busy", 32'(busy_ones()), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom % 200) != 0;
      rd_write_en = $urandom % 2;
      rd_addr = 5'($urandom_range(0, 7));
      rd_warp_id = ($urandom % 8 == 0)
        ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 3));
      case ($urandom % 4)
        0: rd_thread_mask = '0;
        1: rd_thread_mask = '1;
        default: rd_thread_mask = $urandom;
      endcase
      for (int l = 0; l < 32; l++) rd_data[l] = $urandom;
      if ($urandom % 2 == 0) begin
        rs1_addr = rd_addr;
        rs1_warp_id = rd_warp_id;
      end else begin
        rs1_addr = 5'($urandom_range(0, 7));
        rs1_warp_id = 6'($urandom_range(0, 4));
      end
      rs2_addr = 5'($urandom_range(0, 7));
      rs2_warp_id = ($urandom % 4 == 0) ? rd_warp_id
                                        : 6'($urandom_range(0, 3));
      clear_busy_en = $urandom % 2;
      if ($urandom % 4 == 0) begin
        clear_busy_reg = rd_addr;
        clear_busy_warp = rd_warp_id;
      end else begin
        clear_busy_reg = 5'($urandom_range(0, 7));
        clear_busy_warp = 6'($urandom_range(0, 4));
      end
      cyc();
    end

    rst_n = 1'b1;
    rd_write_en = 1'b0;
    clear_busy_en = 1'b0;
    cyc();
    cyc();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
